// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU front end: the operation select
// encodings understood by the 1-bit logic slice, the sequencer state set and
// small helpers that classify an opsel value.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Operation select encodings driven onto the slice.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift ops route the carry through the slice; logic ops ignore it.
  function automatic logic is_shift(input logic [2:0] opsel);
    return opsel[2];
  endfunction

  // Only a right shift walks the operand from MSB to LSB, so that each bit
  // leaving the slice on Cout lands one position lower on the next cycle.
  function automatic logic is_msb_first(input logic [2:0] opsel);
    return opsel[2] & opsel[0];
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// ---------------------------------------------------------------------------
// alu_serial_seq_if
// Bundles the request/response handshake and the slice-facing signals of the
// bit-serial sequencer.
//   start/opsel/a/b/shift_in : operation request (environment -> sequencer)
//   busy/done/result/cout_final : status and assembled result
//   slice_op1/op2/opsel/cin  : per-bit drive towards the 1-bit logic slice
//   slice_result/slice_cout  : per-bit return from the slice
// Modports: master = requester plus slice side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [2:0]       opsel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             shift_in;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_final;

  logic             slice_op1;
  logic             slice_op2;
  logic [2:0]       slice_opsel;
  logic             slice_cin;
  logic             slice_result;
  logic             slice_cout;

  modport master (
    output start, opsel, a, b, shift_in,
    output slice_result, slice_cout,
    input  busy, done, result, cout_final,
    input  slice_op1, slice_op2, slice_opsel, slice_cin
  );

  modport slave (
    input  start, opsel, a, b, shift_in,
    input  slice_result, slice_cout,
    output busy, done, result, cout_final,
    output slice_op1, slice_op2, slice_opsel, slice_cin
  );

endinterface

// File: rtl/alu_serial_bitctr.sv
// ---------------------------------------------------------------------------
// alu_serial_bitctr
// Loadable up/down bit-index counter for the serial sequencer.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (idx=0, direction=up)
//   load : start a new walk; idx loads 0 (dir=0) or WIDTH-1 (dir=1)
//   dir  : walk direction sampled on load, 1 = count down (MSB first)
//   en   : advance one position
//   idx  : current bit index
//   last : idx sits on the terminal position of the current walk
// The counter saturates at the terminal position instead of wrapping, so a
// stray enable after the last bit cannot alias back to bit 0.
// ---------------------------------------------------------------------------
module alu_serial_bitctr #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       dir,
  input  logic                       en,
  output logic [$clog2(WIDTH)-1:0]   idx,
  output logic                       last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(WIDTH - 1);

  // Direction is latched at load so the terminal test stays stable for the
  // whole walk even if the requester changes opsel meanwhile.
  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      dir_q <= dir;
      idx   <= dir ? IDX_MAX : '0;
    end else if (en && !last) begin
      idx <= dir_q ? (idx - 1'b1) : (idx + 1'b1);
    end
  end

  assign last = dir_q ? (idx == '0) : (idx == IDX_MAX);

endmodule

// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial sequencer in front of the 1-bit logic slice. An accepted start
// captures the operands, then one bit per cycle is presented to the slice and
// its result bit is written into a shadow register while its carry is fed
// back into the next bit. After WIDTH bits the shadow is published as result
// together with the final carry, and done pulses for one cycle.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : alu_serial_seq_if.slave
//     start/opsel/a/b/shift_in : request, sampled only while idle
//     busy   : high during the WIDTH bit cycles
//     done   : one-cycle pulse after the last bit
//     result/cout_final : assembled result, held until the next done
//     slice_* : per-bit drive to and return from the 1-bit slice
// Timing: start seen in cycle 0 -> busy cycles 1..WIDTH -> done in cycle
// WIDTH+1 -> idle again in cycle WIDTH+2.
// ---------------------------------------------------------------------------
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_serial_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       opsel_reg;
  logic             carry;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  logic             accept;
  logic             running;
  logic [CNT_W-1:0] idx;
  logic             last;

  assign accept  = (state == S_IDLE) && bus.start;
  assign running = (state == S_RUN);

  alu_serial_bitctr #(
    .WIDTH (WIDTH)
  ) u_bitctr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dir  (is_msb_first(bus.opsel)),
    .en   (running),
    .idx  (idx),
    .last (last)
  );

  // Shadow with the bit returned this cycle already merged in; on the last
  // bit this is the complete word, published in the same edge.
  always_comb begin
    shadow_next      = shadow;
    shadow_next[idx] = bus.slice_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      opsel_reg <= '0;
      carry     <= 1'b0;
      shadow    <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            opsel_reg <= bus.opsel;
            // The fill bit enters the chain as the carry into the first bit.
            carry     <= bus.shift_in;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          shadow <= shadow_next;
          carry  <= bus.slice_cout;
          if (last) begin
            // Result and carry update only here, so observers never see a
            // partially assembled word.
            result_q <= shadow_next;
            cout_q   <= is_shift(opsel_reg) ? bus.slice_cout : 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Slice drive is gated by RUN so the slice sees quiet zeros while idle.
  assign bus.slice_op1   = running ? a_reg[idx] : 1'b0;
  assign bus.slice_op2   = running ? b_reg[idx] : 1'b0;
  assign bus.slice_opsel = running ? opsel_reg : 3'b000;
  assign bus.slice_cin   = running ? (is_shift(opsel_reg) ? carry : 1'b0) : 1'b0;

  assign bus.busy       = running;
  assign bus.done       = (state == S_DONE);
  assign bus.result     = result_q;
  assign bus.cout_final = cout_q;

endmodule
